// File: rtl/fetch_redirect_pkg.sv
// Shared CPU definitions for the fetch-redirect sequencer: reset PC,
// exception vectors and the redirect FSM state encoding.
package fetch_redirect_pkg;

  localparam logic [31:0] RESET_PC      = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_BEV   = 32'hBFC0_0380;
  localparam logic [31:0] EXC_VEC_NORM  = 32'h8000_0180;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_DS = 2'd1,
    HOLD    = 2'd2
  } redirect_state_t;

endpackage

// File: rtl/fetch_redirect_if.sv
// Redirect request / fetch-address bundle between the pipeline and the IF sequencer.
// Handshake: requests are single-cycle level strobes sampled on the rising edge;
// there is no ready. While redirect_pendingF is high decode is held, and new jump
// requests are ignored. pcF/fetch_reqF/flush_fetchF are registered outputs.
interface fetch_redirect_if;
  import fetch_redirect_pkg::*;

  logic            stallF;
  logic            jump_takeD;
  logic [31:0]     jump_targetD;
  logic            ds_fetchedD;
  logic            resolve_validE;
  logic [31:0]     resolve_targetE;
  logic            exc_valid;
  logic [31:0]     exc_target;
  logic [31:0]     pcF;
  logic            fetch_reqF;
  logic            flush_fetchF;
  logic            redirect_pendingF;
  redirect_state_t state;

  modport master (
    output stallF, jump_takeD, jump_targetD, ds_fetchedD,
           resolve_validE, resolve_targetE, exc_valid, exc_target,
    input  pcF, fetch_reqF, flush_fetchF, redirect_pendingF, state
  );

  modport slave (
    input  stallF, jump_takeD, jump_targetD, ds_fetchedD,
           resolve_validE, resolve_targetE, exc_valid, exc_target,
    output pcF, fetch_reqF, flush_fetchF, redirect_pendingF, state
  );

endinterface

// File: rtl/fetch_redirect.sv
// IF-stage PC sequencer: sequential dual-issue fetch, delay-slot-aware jumps,
// and redirects held across fetch stalls.
module fetch_redirect
  import fetch_redirect_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  fetch_redirect_if.slave  bus
);

  redirect_state_t state, state_nxt;
  logic [31:0]     pc, pc_nxt;
  logic [31:0]     pend_target, pend_nxt;
  logic            flush, flush_nxt;
  logic            resetn_q;

  logic [31:0]     pc_seq;
  logic            redirect_now;
  logic            jump_owed;
  logic [31:0]     redirect_target;

  assign pc_seq = {pc[31:3] + 29'd1, 3'b000};

  // Exceptions win in any state; resolves only outside HOLD; decode jumps only in RUN.
  assign redirect_now = bus.exc_valid
                      || (bus.resolve_validE && (state != HOLD))
                      || (bus.jump_takeD && bus.ds_fetchedD && (state == RUN));
  assign jump_owed    = bus.jump_takeD && !bus.ds_fetchedD && (state == RUN);

  always_comb begin
    redirect_target = bus.jump_targetD;
    if (bus.exc_valid)           redirect_target = bus.exc_target;
    else if (bus.resolve_validE) redirect_target = bus.resolve_targetE;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_target;
    flush_nxt = 1'b0;
    if (redirect_now) begin
      pend_nxt = redirect_target;
      if (!bus.stallF) begin
        pc_nxt    = redirect_target;
        state_nxt = RUN;
        flush_nxt = 1'b1;
      end else begin
        state_nxt = HOLD;
      end
    end else if (jump_owed) begin
      // The delay slot is fetched first; a stall just defers that fetch.
      pend_nxt  = bus.jump_targetD;
      state_nxt = WAIT_DS;
      if (!bus.stallF) pc_nxt = pc_seq;
    end else if (!bus.stallF) begin
      if (state == RUN) begin
        pc_nxt = pc_seq;
      end else begin
        pc_nxt    = pend_target;
        state_nxt = RUN;
        flush_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) pc <= RESET_PC;
    else         pc <= pc_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) pend_target <= 32'd0;
    else         pend_target <= pend_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      flush    <= 1'b0;
      resetn_q <= 1'b0;
    end else begin
      flush    <= flush_nxt;
      resetn_q <= 1'b1;
    end
  end

  assign bus.pcF               = pc;
  assign bus.fetch_reqF        = resetn_q;
  assign bus.flush_fetchF      = flush;
  assign bus.redirect_pendingF = (state != RUN);
  assign bus.state             = state;

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect with hand-computed PC/flush/pending sequences.
module tb_fetch_redirect;
  import fetch_redirect_pkg::*;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_pass;

  fetch_redirect_if bus ();

  fetch_redirect dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // Outputs are registered, so sampling 1 time unit after the edge is stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.jump_takeD      = 1'b0;
    bus.jump_targetD    = 32'd0;
    bus.ds_fetchedD     = 1'b0;
    bus.resolve_validE  = 1'b0;
    bus.resolve_targetE = 32'd0;
    bus.exc_valid       = 1'b0;
    bus.exc_target      = 32'd0;
  endtask

  task automatic drive_jump(input logic [31:0] tgt, input logic ds);
    bus.jump_takeD   = 1'b1;
    bus.jump_targetD = tgt;
    bus.ds_fetchedD  = ds;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic flush,
                            input logic pend, input redirect_state_t st);
    check({tag, ".pc"},    bus.pcF, pc);
    check({tag, ".flush"}, 32'(bus.flush_fetchF), 32'(flush));
    check({tag, ".pend"},  32'(bus.redirect_pendingF), 32'(pend));
    check({tag, ".state"}, 32'(bus.state), 32'(st));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    bus.stallF = 1'b0;
    clear_reqs();

    // reset for two edges
    step();
    step();
    expect_out("rst", 32'hBFC0_0000, 1'b0, 1'b0, RUN);
    check("rst.req", 32'(bus.fetch_reqF), 32'd0);
    resetn = 1'b1;
    step();
    check("seq0.pc",  bus.pcF, 32'hBFC0_0008);
    check("seq0.req", 32'(bus.fetch_reqF), 32'd1);
    step();
    expect_out("seq1", 32'hBFC0_0010, 1'b0, 1'b0, RUN);

    // jump owing its delay slot
    drive_jump(32'h8000_0100, 1'b0);
    step();
    expect_out("jds.slot", 32'hBFC0_0018, 1'b0, 1'b1, WAIT_DS);
    clear_reqs();
    step();
    expect_out("jds.tgt", 32'h8000_0100, 1'b1, 1'b0, RUN);
    step();
    expect_out("jds.seq", 32'h8000_0108, 1'b0, 1'b0, RUN);

    // jump whose delay slot is already fetched
    drive_jump(32'h8000_0200, 1'b1);
    step();
    expect_out("jf.tgt", 32'h8000_0200, 1'b1, 1'b0, RUN);
    clear_reqs();
    step();
    expect_out("jf.seq", 32'h8000_0208, 1'b0, 1'b0, RUN);

    // resolve redirect arriving under a 3-cycle stall
    bus.stallF          = 1'b1;
    bus.resolve_validE  = 1'b1;
    bus.resolve_targetE = 32'h8000_0300;
    step();
    expect_out("stl.0", 32'h8000_0208, 1'b0, 1'b1, HOLD);
    clear_reqs();
    drive_jump(32'h8000_0900, 1'b1);
    step();
    expect_out("stl.1", 32'h8000_0208, 1'b0, 1'b1, HOLD);
    clear_reqs();
    step();
    expect_out("stl.2", 32'h8000_0208, 1'b0, 1'b1, HOLD);
    bus.stallF = 1'b0;
    step();
    expect_out("stl.tgt", 32'h8000_0300, 1'b1, 1'b0, RUN);
    step();
    expect_out("stl.seq", 32'h8000_0308, 1'b0, 1'b0, RUN);

    // exception beats resolve while waiting on a delay slot
    drive_jump(32'h8000_0500, 1'b0);
    step();
    expect_out("pri.slot", 32'h8000_0310, 1'b0, 1'b1, WAIT_DS);
    clear_reqs();
    bus.exc_valid       = 1'b1;
    bus.exc_target      = EXC_VEC_BEV;
    bus.resolve_validE  = 1'b1;
    bus.resolve_targetE = 32'h8000_0400;
    step();
    expect_out("pri.exc", 32'hBFC0_0380, 1'b1, 1'b0, RUN);
    clear_reqs();
    step();
    expect_out("pri.seq", 32'hBFC0_0388, 1'b0, 1'b0, RUN);

    // reset while a target is pending
    drive_jump(32'h8000_0600, 1'b0);
    step();
    expect_out("rds.slot", 32'hBFC0_0390, 1'b0, 1'b1, WAIT_DS);
    clear_reqs();
    bus.stallF = 1'b1;
    resetn     = 1'b0;
    step();
    expect_out("rds.rst", 32'hBFC0_0000, 1'b0, 1'b0, RUN);
    check("rds.req", 32'(bus.fetch_reqF), 32'd0);
    bus.stallF = 1'b0;
    resetn     = 1'b1;
    step();
    expect_out("rds.seq", 32'hBFC0_0008, 1'b0, 1'b0, RUN);

    // wrap at the top of the address space
    bus.exc_valid  = 1'b1;
    bus.exc_target = 32'hFFFF_FFF8;
    step();
    expect_out("wrap.top", 32'hFFFF_FFF8, 1'b1, 1'b0, RUN);
    clear_reqs();
    step();
    expect_out("wrap.zero", 32'h0000_0000, 1'b0, 1'b0, RUN);

    // owed delay slot with the jump itself stalled
    bus.stallF = 1'b1;
    drive_jump(32'h8000_0700, 1'b0);
    step();
    expect_out("sds.0", 32'h0000_0000, 1'b0, 1'b1, WAIT_DS);
    clear_reqs();
    step();
    expect_out("sds.1", 32'h0000_0000, 1'b0, 1'b1, WAIT_DS);
    bus.stallF = 1'b0;
    step();
    expect_out("sds.tgt", 32'h8000_0700, 1'b1, 1'b0, RUN);

    // stalled in RUN with no request holds pcF
    bus.stallF = 1'b1;
    step();
    expect_out("hold", 32'h8000_0700, 1'b0, 1'b0, RUN);
    bus.stallF = 1'b0;
    step();
    expect_out("hold.go", 32'h8000_0708, 1'b0, 1'b0, RUN);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
